// File: rtl/booth_mac_if.sv
// Operand/result bundle for the Booth multiply-accumulate engine.
// master: register-file side driving operands and commands.
// slave : the MAC engine itself.
//
// Handshake: start and clear_acc are level requests sampled on a rising clock
// edge only while busy is low. There is no ready/accept signal. A start seen
// in IDLE is always taken. A start or clear_acc seen while busy is dropped.
// booth_ready is a single-cycle strobe meaning m holds a freshly accumulated
// value. busy is low in that same cycle, so a new start may be presented then.
interface booth_mac_if #(
   parameter int OP_WIDTH  = 16,
   parameter int ACC_WIDTH = 32
);
   logic                 start;
   logic                 clear_acc;
   logic [OP_WIDTH-1:0]  a;
   logic [OP_WIDTH-1:0]  b;
   logic [ACC_WIDTH-1:0] m;
   logic                 booth_ready;
   logic                 busy;
   logic                 overflow;
   logic [1:0]           dbg_state;

   modport master (
      output start, clear_acc, a, b,
      input  m, booth_ready, busy, overflow, dbg_state
   );

   modport slave (
      input  start, clear_acc, a, b,
      output m, booth_ready, busy, overflow, dbg_state
   );
endinterface

// File: rtl/booth_mac.sv
// Sequential radix-2 Booth signed multiply-accumulate engine.
// A multiply takes one load edge, OP_WIDTH Booth steps and one accumulate
// edge. The accumulator wraps modulo 2^ACC_WIDTH and keeps a sticky
// signed-overflow flag.
module booth_mac #(
   parameter int OP_WIDTH  = 16,
   parameter int ACC_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   booth_mac_if.slave  bus
);
   localparam int CNT_W = $clog2(OP_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OP_WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ITER  = 2'd1;
   localparam logic [1:0] S_ACCUM = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [OP_WIDTH-1:0]  mc_q, mc_d;
   // H is one bit wider than the operands so that subtracting the
   // most-negative multiplicand cannot overflow.
   logic [OP_WIDTH:0]    h_q, h_d;
   logic [OP_WIDTH-1:0]  q_q, q_d;
   logic                 q1_q, q1_d;
   logic [ACC_WIDTH-1:0] m_q, m_d;
   logic                 ovf_q, ovf_d;
   logic                 rdy_q, rdy_d;

   logic [OP_WIDTH:0]           mc_ext;
   logic [OP_WIDTH:0]           step_sum;
   logic signed [2*OP_WIDTH-1:0] prod_raw;
   logic [ACC_WIDTH-1:0]        prod_ext;
   logic [ACC_WIDTH-1:0]        acc_sum;
   logic                        acc_ovf;

   assign mc_ext   = (OP_WIDTH + 1)'($signed(mc_q));
   assign prod_raw = {h_q[OP_WIDTH-1:0], q_q};
   assign prod_ext = ACC_WIDTH'(prod_raw);
   assign acc_sum  = m_q + prod_ext;
   assign acc_ovf  = (m_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != m_q[ACC_WIDTH-1]);

   // Booth add/subtract selected by the two low bits of {Q, q_1}.
   always_comb begin
      step_sum = h_q;
      case ({q_q[0], q1_q})
         2'b01:   step_sum = h_q + mc_ext;
         2'b10:   step_sum = h_q - mc_ext;
         default: step_sum = h_q;
      endcase
   end

   // Next-state logic for the FSM and the datapath registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mc_d    = mc_q;
      h_d     = h_q;
      q_d     = q_q;
      q1_d    = q1_q;
      m_d     = m_q;
      ovf_d   = ovf_q;
      rdy_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A clear that arrives with a start zeroes the accumulator first.
            // The new product then accumulates onto zero.
            if (bus.clear_acc) begin
               m_d   = '0;
               ovf_d = 1'b0;
            end
            if (bus.start) begin
               mc_d    = bus.a;
               h_d     = '0;
               q_d     = bus.b;
               q1_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            // Arithmetic right shift of {H, Q, q_1}, applied after the add.
            h_d   = {step_sum[OP_WIDTH], step_sum[OP_WIDTH:1]};
            q_d   = {step_sum[0], q_q[OP_WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            m_d     = acc_sum;
            ovf_d   = ovf_q | acc_ovf;
            rdy_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mc_q    <= '0;
         h_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         m_q     <= '0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mc_q    <= mc_d;
         h_q     <= h_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         m_q     <= m_d;
         ovf_q   <= ovf_d;
         rdy_q   <= rdy_d;
      end
   end

   assign bus.m           = m_q;
   assign bus.booth_ready = rdy_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.overflow    = ovf_q;
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_booth_mac.sv
// Directed bench for booth_mac: a table of accumulate vectors followed by
// hand-written sequences covering the multi-cycle corner cases.
module tb_booth_mac;
   logic clk;
   logic rst_n;

   booth_mac_if #(.OP_WIDTH(16), .ACC_WIDTH(32)) bus ();

   booth_mac #(.OP_WIDTH(16), .ACC_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        clr;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp_m;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [12];

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Presents a start for one edge, then scrambles the operands so that
   // any dependence on a/b after capture shows up in the result.
   task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic clr);
      bus.start     = 1'b1;
      bus.clear_acc = clr;
      bus.a         = a;
      bus.b         = b;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.clear_acc = 1'b0;
      bus.a         = 16'($urandom_range(0, 65535));
      bus.b         = 16'($urandom_range(0, 65535));
   endtask

   // Waits (bounded) for booth_ready; reports edges from the start edge and
   // the number of sampled cycles with busy high before the pulse.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = bus.busy ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.booth_ready) break;
         if (bus.busy) busy_cnt++;
      end
   endtask

   // booth_ready must never be high two cycles running, and busy is low with it.
   logic prev_rdy = 1'b0;
   always @(negedge clk) begin
      if (rst_n && bus.booth_ready) begin
         tests++;
         if (prev_rdy || bus.busy) begin
            fails++;
            $display("FAIL ready_pulse: prev_ready=%0b busy=%0b expected 0 0", prev_rdy, bus.busy);
         end
      end
      prev_rdy = rst_n && bus.booth_ready;
   end

   initial begin
      int lat;
      int bcnt;
      int pulses;
      logic [31:0] m_at_pulse;

      vecs[0]  = '{1'b1, 16'h0003, 16'h0005, 32'h0000000F, 1'b0};
      vecs[1]  = '{1'b0, 16'hFFF9, 16'h0006, 32'hFFFFFFE5, 1'b0};
      vecs[2]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b0};
      vecs[3]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 1'b0};
      vecs[4]  = '{1'b0, 16'h8000, 16'h8000, 32'h00008000, 1'b0};
      vecs[5]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0};
      vecs[6]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'h3FFF0002, 1'b0};
      vecs[7]  = '{1'b0, 16'h0001, 16'h8000, 32'h3FFE8002, 1'b0};
      vecs[8]  = '{1'b1, 16'h0000, 16'h04D2, 32'h00000000, 1'b0};
      vecs[9]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b0};
      vecs[10] = '{1'b0, 16'h8000, 16'h8000, 32'h80000000, 1'b1};
      vecs[11] = '{1'b0, 16'h0001, 16'h0001, 32'h80000001, 1'b1};

      // Reset phase.
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.clear_acc = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_m", bus.m, 32'h0);
      check("reset_ready", {31'b0, bus.booth_ready}, 32'h0);
      check("reset_busy", {31'b0, bus.busy}, 32'h0);
      check("reset_ovf", {31'b0, bus.overflow}, 32'h0);
      check("reset_state", {30'b0, bus.dbg_state}, 32'h0);
      rst_n = 1'b1;

      // Table of accumulate vectors, applied in order.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         launch(vecs[i].a, vecs[i].b, vecs[i].clr);
         wait_done(lat, bcnt);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
         check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd17);
         check($sformatf("vec%0d_m", i), bus.m, vecs[i].exp_m);
         check($sformatf("vec%0d_ovf", i), {31'b0, bus.overflow}, {31'b0, vecs[i].exp_ovf});
      end

      // clear_acc alone clears the accumulator and the sticky overflow.
      @(negedge clk);
      bus.clear_acc = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_acc = 1'b0;
      check("clear_m", bus.m, 32'h0);
      check("clear_ovf", {31'b0, bus.overflow}, 32'h0);
      check("clear_busy", {31'b0, bus.busy}, 32'h0);

      // start and clear_acc while busy are ignored; operands change mid-op.
      @(negedge clk);
      launch(16'd2, 16'd2, 1'b0);
      pulses     = 0;
      m_at_pulse = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 3 || cyc == 10) begin
            bus.start     = 1'b1;
            bus.clear_acc = 1'b1;
            bus.a         = 16'd9;
            bus.b         = 16'd9;
         end else begin
            bus.start     = 1'b0;
            bus.clear_acc = 1'b0;
         end
         @(posedge clk);
         #1;
         if (bus.booth_ready) begin
            pulses++;
            m_at_pulse = bus.m;
            check("ignore_pulse_edge", 32'(cyc), 32'd17);
         end
      end
      check("ignore_pulses", 32'(pulses), 32'd1);
      check("ignore_m", m_at_pulse, 32'd4);
      check("ignore_m_final", bus.m, 32'd4);

      // Back-to-back: a start in the booth_ready cycle is accepted.
      @(negedge clk);
      launch(16'd5, 16'd5, 1'b0);
      wait_done(lat, bcnt);
      check("b2b_first_latency", 32'(lat), 32'd17);
      check("b2b_first_m", bus.m, 32'd29);
      launch(16'd3, 16'd3, 1'b0);
      wait_done(lat, bcnt);
      check("b2b_second_latency", 32'(lat), 32'd17);
      check("b2b_second_m", bus.m, 32'd38);

      // Reset mid-operation abandons the multiply.
      @(negedge clk);
      launch(16'd100, 16'd100, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_m", bus.m, 32'h0);
      check("midrst_busy", {31'b0, bus.busy}, 32'h0);
      check("midrst_ready", {31'b0, bus.booth_ready}, 32'h0);
      check("midrst_state", {30'b0, bus.dbg_state}, 32'h0);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.booth_ready) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
      @(negedge clk);
      launch(16'd100, 16'd100, 1'b0);
      wait_done(lat, bcnt);
      check("post_rst_latency", 32'(lat), 32'd17);
      check("post_rst_m", bus.m, 32'h00002710);
      check("post_rst_ovf", {31'b0, bus.overflow}, 32'h0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
